// File: rtl/nes_pad_reader.sv
// NES controller (4021 shift register) poller: drives latch/clock, samples serial
// data through a synchronizer and publishes an active-high button byte once per frame.
module nes_pad_reader #(
  parameter int CLK_DIV  = 6,
  parameter int POLL_GAP = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_en,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int GAP_W = $clog2(POLL_GAP + 1);

  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  SHIFT_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(POLL_GAP);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q;
  logic [2:0]        bit_idx_q;
  logic [GAP_W-1:0]  gap_q;
  logic [7:0]        shift_q;
  logic [1:0]        sync_q;
  logic              phase_last;

  assign phase_last = (phase_q == ((state_q == LATCH) ? LATCH_LAST : SHIFT_LAST));

  // NOTE: state and every other flop use non-blocking assignments so all
  // registers update together from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (poll_en && gap_q == '0) state_d = LATCH;
      LATCH:   if (phase_last) state_d = LOW;
      LOW:     if (phase_last) state_d = (bit_idx_q == 3'd7) ? DONE : HIGH;
      HIGH:    if (phase_last) state_d = LOW;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= '0;
      bit_idx_q <= '0;
      gap_q     <= '0;
      shift_q   <= '0;
      sync_q    <= 2'b11;
      buttons   <= '0;
      valid     <= 1'b0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pad_data};

      if (phase_last || state_q == IDLE || state_q == DONE) phase_q <= '0;
      else                                                   phase_q <= phase_q + 1'b1;

      if (state_q == LATCH) bit_idx_q <= '0;
      else if (state_q == LOW && phase_last && bit_idx_q != 3'd7) bit_idx_q <= bit_idx_q + 3'd1;

      // Controller data is active-low; store pressed as 1.
      if (state_q == LOW && phase_last) shift_q[bit_idx_q] <= ~sync_q[1];

      if (state_q == DONE)  gap_q <= GAP_LOAD;
      else if (gap_q != '0) gap_q <= gap_q - 1'b1;

      if (state_q == DONE) buttons <= shift_q;
      valid <= (state_q == DONE);

      // Pad-facing outputs are registered from the next state so they are glitch-free.
      pad_latch <= (state_d == LATCH);
      pad_clk   <= (state_d == HIGH);
      busy      <= (state_d == LATCH) || (state_d == LOW) || (state_d == HIGH);
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural 4021 controller model.
module tb_nes_pad_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       poll_en = 1'b0;
  logic       pad_data;
  logic       pad_latch, pad_clk, valid, busy;
  logic [7:0] buttons;

  logic [7:0] press = 8'h00;
  int         pad_idx = 8;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  nes_pad_reader #(.CLK_DIV(2), .POLL_GAP(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .poll_en   (poll_en),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .buttons   (buttons),
    .valid     (valid),
    .busy      (busy)
  );

  // 4021 model: parallel load while latched, shift one bit per pad_clk rise.
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_idx = 0;
    else if (pad_idx < 8) pad_idx = pad_idx + 1;
  end
  assign pad_data = (pad_idx < 8) ? ~press[pad_idx[2:0]] : 1'b1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; poll_en = 1'b0;
    repeat (3) step();
    n_checks++; if (pad_latch !== 1'b0) begin n_fail++; $display("FAIL reset_latch got %b want 0", pad_latch); end
    n_checks++; if (pad_clk !== 1'b0)   begin n_fail++; $display("FAIL reset_clk got %b want 0", pad_clk); end
    n_checks++; if (buttons !== 8'h00)  begin n_fail++; $display("FAIL reset_buttons got %h want 00", buttons); end
    n_checks++; if (valid !== 1'b0)     begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    step();
    n_checks++; if (pad_latch !== 1'b0) begin n_fail++; $display("FAIL idle_no_poll got latch %b want 0", pad_latch); end
  endtask

  // Frame waveform plus gap: cycle 0 = pad_latch rise, valid at 35, next latch at 46.
  task automatic test_frame_and_gap();
    logic e_latch, e_clk, e_busy, e_valid;
    logic [7:0] e_btn;
    press = 8'h89;
    poll_en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      e_latch = (k < 4) || (k >= 46);
      e_clk   = (k >= 4) && (k < 32) && (((k - 4) % 4) >= 2);
      e_busy  = (k < 34) || (k >= 46);
      e_valid = (k == 35);
      e_btn   = (k >= 35) ? 8'h89 : 8'h00;
      n_checks++; if (pad_latch !== e_latch) begin n_fail++; $display("FAIL frame_latch k=%0d got %b want %b", k, pad_latch, e_latch); end
      n_checks++; if (pad_clk !== e_clk)     begin n_fail++; $display("FAIL frame_clk k=%0d got %b want %b", k, pad_clk, e_clk); end
      n_checks++; if (busy !== e_busy)       begin n_fail++; $display("FAIL frame_busy k=%0d got %b want %b", k, busy, e_busy); end
      n_checks++; if (valid !== e_valid)     begin n_fail++; $display("FAIL frame_valid k=%0d got %b want %b", k, valid, e_valid); end
      n_checks++; if (buttons !== e_btn)     begin n_fail++; $display("FAIL frame_buttons k=%0d got %h want %h", k, buttons, e_btn); end
    end
  endtask

  task automatic test_poll_drop();
    bit seen;
    int stray;
    poll_en = 1'b0;
    wait_valid(80, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL drop_valid got none want pulse"); end
    n_checks++; if (buttons !== 8'h89) begin n_fail++; $display("FAIL drop_buttons got %h want 89", buttons); end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pad_latch || busy || valid) stray++;
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL drop_no_new_frame got %0d active cycles want 0", stray); end
  endtask

  task automatic test_patterns();
    bit seen;
    press = 8'h00;
    poll_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_valid(80, seen);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL nopad_valid frame %0d got none", f); end
      n_checks++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL nopad_buttons frame %0d got %h want 00", f, buttons); end
    end
    press = 8'hFF;
    wait_valid(80, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL allpress_valid got none"); end
    n_checks++; if (buttons !== 8'hFF) begin n_fail++; $display("FAIL allpress_buttons got %h want FF", buttons); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int glitches;
    press = 8'h01;
    wait_valid(80, seen);
    n_checks++; if (buttons !== 8'h01) begin n_fail++; $display("FAIL change_first got %h want 01", buttons); end
    press = 8'h10;
    glitches = 0;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      step();
      if (valid) seen = 1'b1;
      else if (buttons !== 8'h01) glitches++;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL change_valid got none"); end
    n_checks++; if (glitches != 0) begin n_fail++; $display("FAIL change_hold got %0d early changes want 0", glitches); end
    n_checks++; if (buttons !== 8'h10) begin n_fail++; $display("FAIL change_second got %h want 10", buttons); end
    step();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL valid_width got %b want 0", valid); end
    n_checks++; if (buttons !== 8'h10) begin n_fail++; $display("FAIL change_stable got %h want 10", buttons); end
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    int rises;
    logic prev_clk;
    press = 8'h55;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      step();
      if (pad_latch) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_latch got none"); end
    // Advance to the first LOW cycle of bit 4 (after the 4th pad_clk pulse).
    rises = 0;
    prev_clk = pad_clk;
    for (int i = 0; i < 80; i++) begin
      step();
      if (pad_clk && !prev_clk) rises++;
      if (rises == 4 && !pad_clk) break;
      prev_clk = pad_clk;
    end
    n_checks++; if (rises != 4 || pad_clk !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_position got rises=%0d clk=%b busy=%b want 4/0/1", rises, pad_clk, busy);
    end
    n_checks++; if (buttons !== 8'h10) begin n_fail++; $display("FAIL rstmid_hold got %h want 10", buttons); end
    rst = 1'b1;
    step();
    n_checks++; if (pad_latch !== 1'b0) begin n_fail++; $display("FAIL rstmid_latch0 got %b want 0", pad_latch); end
    n_checks++; if (pad_clk !== 1'b0)   begin n_fail++; $display("FAIL rstmid_clk0 got %b want 0", pad_clk); end
    n_checks++; if (buttons !== 8'h00)  begin n_fail++; $display("FAIL rstmid_buttons got %h want 00", buttons); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++; if (valid !== 1'b0)     begin n_fail++; $display("FAIL rstmid_valid got %b want 0", valid); end
    step();
    rst = 1'b0;
    step();
    n_checks++; if (pad_latch !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart got latch %b want 1", pad_latch); end
    n_checks++; if (buttons !== 8'h00)  begin n_fail++; $display("FAIL rstmid_discard got %h want 00", buttons); end
    wait_valid(80, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_fresh_valid got none"); end
    n_checks++; if (buttons !== 8'h55) begin n_fail++; $display("FAIL rstmid_fresh_buttons got %h want 55", buttons); end
  endtask

  initial begin
    test_reset();
    test_frame_and_gap();
    test_poll_drop();
    test_patterns();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Polls a standard NES controller (4021 shift register) over latch/clock/data and presents a debounced-by-frame, active-high 8-bit button byte to the emulator top level.
- Sits directly upstream of the NES emulator top: its buttons/valid outputs feed the controller port read path in place of raw ui_in pins.
- Generates pad_latch and pad_clk on dedicated outputs, samples pad_data on a dedicated input, and auto-polls at a fixed rate while enabled.

Parameters:
- CLK_DIV, 6, pad_latch/pad_clk half-period in clk cycles; legal range >=2.
- POLL_GAP, 1000, idle clk cycles from end of one frame to start of the next; legal range >=1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- poll_en  input  1  level; high enables continuous polling
- pad_data  input  1  serial data from controller, active-low (0 = pressed), asynchronous
- pad_latch  output  1  latch pulse to controller, active-high
- pad_clk  output  1  shift clock to controller, idle low
- buttons  output  8  active-high button state: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right
- valid  output  1  one-cycle pulse when buttons has just been updated
- busy  output  1  high while a frame (LATCH through SAMPLE of bit 7) is in progress

Behaviour:
- Reset: pad_latch=0, pad_clk=0, buttons=8'h00, valid=0, busy=0, FSM=IDLE, gap counter=0, synchronizer flops=1.
- pad_data passes through a 2-flop synchronizer; all sampling uses the synchronized value. CLK_DIV>=2 guarantees data has been stable >=4 cycles at each sample.
- Counters: phase counter ceil(log2(2*CLK_DIV)) bits; bit index 3 bits; gap counter ceil(log2(POLL_GAP+1)) bits. The shift register is 8 bits and fills LSB-first.
- IDLE: when the gap counter is nonzero, it decrements every cycle. When poll_en=1 and gap=0, go to LATCH on the next edge.
- LATCH (2*CLK_DIV cycles): pad_latch=1, busy=1. Then go to LOW with bit index 0.
- LOW (CLK_DIV cycles): pad_latch=0, pad_clk=0. On the last cycle, shift in ~sync_data at the current bit index.
  - If index=7, go to DONE.
  - Otherwise, increment the index and go to HIGH.
- HIGH (CLK_DIV cycles): pad_clk=1. Then go to LOW. There are exactly 7 pad_clk pulses per frame.
- DONE (1 cycle): buttons<=shift register, valid=1 for this cycle only, busy=0, gap counter<=POLL_GAP. Then go to IDLE.
- Frame length: 17*CLK_DIV cycles from pad_latch rising to the last sample. valid asserts on the cycle after the last sample.
- buttons holds its value between frames and changes only in DONE.
- poll_en deasserted mid-frame: the frame completes and buttons/valid update normally. No new frame starts while poll_en=0. The gap counter keeps counting down regardless of poll_en.
- poll_en asserted with gap=0 in IDLE: pad_latch rises on the next clock edge.
- rst mid-frame: on the next edge, all outputs return to reset values and the partial frame is discarded (no valid).
- No controller connected (pad_data floats high via pull-up): frame reads buttons=8'h00.

Test Plan:
- CLK_DIV=2, POLL_GAP=10, rst then poll_en=1 -> pad_latch high 4 cycles starting the edge after poll_en is seen, then 7 pad_clk pulses each 2 high/2 low, valid at cycle 35 after latch rise, busy low in the valid cycle.
- Controller model drives A,Start,Right pressed (serial low at bits 0,3,7) -> buttons=8'h89 with a single-cycle valid; buttons is stable until the next DONE.
- pad_data held high (no pad) -> buttons=8'h00 every frame. All buttons pressed -> buttons=8'hFF.
- poll_en held high -> next pad_latch rise exactly 11 cycles after valid (DONE, then 10 gap cycles, then start). poll_en dropped mid-frame -> that frame completes with valid, no further latch.
- rst asserted during SHIFT of bit 4 -> next cycle pad_latch=0, pad_clk=0, buttons=8'h00, busy=0, no valid. With poll_en=1 after release, a fresh full frame runs.
- Press pattern changes between frames (8'h01 then 8'h10) -> buttons steps 8'h01 to 8'h10 only on the second valid, with no intermediate values.
